// File: rtl/lab7_sos_nios2_qsys_0_oci_dct_packer.sv
// Trace atom packer: collects 2-bit atoms into a 30-bit packet and hands it off
// through a one-deep valid/ready output slot, with flush and end-of-trace drain.
`timescale 1ns/100ps
module lab7_sos_nios2_qsys_0_oci_dct_packer #(
    parameter int unsigned CNT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        atom_valid,
    input  logic [1:0]  atom_data,
    output logic        atom_ready,
    input  logic        flush,
    input  logic        test_end_req,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        test_ending,
    output logic        test_has_ended
);

    localparam logic [3:0] LP_MAX = 4'(CNT_MAX);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ENDED
    } state_t;

    state_t      r_state;
    logic [29:0] r_fill_buf;
    logic [3:0]  r_fill_cnt;
    logic        r_flush_pend;
    logic [29:0] r_dct_buffer;
    logic [3:0]  r_dct_count;
    logic        r_pkt_valid;
    logic        r_test_ending;
    logic        r_test_has_ended;

    logic w_full;
    logic w_slot_free;
    logic w_accept;
    logic w_xfer;

    assign w_full      = (r_fill_cnt == LP_MAX);
    assign w_slot_free = !r_pkt_valid || pkt_ready;
    // A full fill register still takes an atom when it is emptied the same cycle.
    assign atom_ready  = (r_state == ST_RUN) && (!w_full || w_slot_free);
    assign w_accept    = atom_valid && atom_ready;
    assign w_xfer      = w_slot_free && (r_fill_cnt != '0)
                         && (w_full || r_flush_pend || (r_state == ST_DRAIN));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_RUN;
            r_fill_buf       <= '0;
            r_fill_cnt       <= '0;
            r_flush_pend     <= 1'b0;
            r_dct_buffer     <= '0;
            r_dct_count      <= '0;
            r_pkt_valid      <= 1'b0;
            r_test_ending    <= 1'b0;
            r_test_has_ended <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_dct_buffer <= r_fill_buf;
                r_dct_count  <= r_fill_cnt;
                r_pkt_valid  <= 1'b1;
                r_fill_buf   <= w_accept ? {28'b0, atom_data} : '0;
                r_fill_cnt   <= w_accept ? 4'd1 : '0;
            end else begin
                if (pkt_ready) begin
                    r_pkt_valid <= 1'b0;
                end
                if (w_accept) begin
                    r_fill_buf <= {r_fill_buf[27:0], atom_data};
                    r_fill_cnt <= r_fill_cnt + 4'd1;
                end
            end

            // A new flush re-arms even when an older pending flush is retired this cycle.
            if ((r_state == ST_RUN) && flush && !test_end_req) begin
                r_flush_pend <= 1'b1;
            end else if (w_xfer || ((r_fill_cnt == '0) && !w_accept)) begin
                r_flush_pend <= 1'b0;
            end

            case (r_state)
                ST_RUN: begin
                    if (test_end_req) begin
                        r_state       <= ST_DRAIN;
                        r_test_ending <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if ((r_fill_cnt == '0) && w_slot_free) begin
                        r_state          <= ST_ENDED;
                        r_test_ending    <= 1'b0;
                        r_test_has_ended <= 1'b1;
                    end
                end
                ST_ENDED: begin
                    r_state <= ST_ENDED;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign dct_buffer     = r_dct_buffer;
    assign dct_count      = r_dct_count;
    assign pkt_valid      = r_pkt_valid;
    assign test_ending    = r_test_ending;
    assign test_has_ended = r_test_has_ended;

endmodule

// File: tb/tb_lab7_sos_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT atom packer: full/flush/drain/reset cases at
// CNT_MAX=15, plus a scoreboarded stream at CNT_MAX=4.
`timescale 1ns/100ps
module tb_lab7_sos_nios2_qsys_0_oci_dct_packer;

    logic clk = 1'b0;
    logic reset_n;

    logic        v15, f15, te15, pr15;
    logic [1:0]  d15;
    logic        rdy15, pv15, ending15, ended15;
    logic [29:0] buf15;
    logic [3:0]  cnt15;

    logic        v4, f4, te4, pr4;
    logic [1:0]  d4;
    logic        rdy4, pv4, ending4, ended4;
    logic [29:0] buf4;
    logic [3:0]  cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] sb_q[$];
    int         pushed;
    int         n_pkt4;

    lab7_sos_nios2_qsys_0_oci_dct_packer #(.CNT_MAX(15)) u_dut15 (
        .clk(clk), .reset_n(reset_n),
        .atom_valid(v15), .atom_data(d15), .atom_ready(rdy15),
        .flush(f15), .test_end_req(te15),
        .dct_buffer(buf15), .dct_count(cnt15),
        .pkt_valid(pv15), .pkt_ready(pr15),
        .test_ending(ending15), .test_has_ended(ended15)
    );

    lab7_sos_nios2_qsys_0_oci_dct_packer #(.CNT_MAX(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .atom_valid(v4), .atom_data(d4), .atom_ready(rdy4),
        .flush(f4), .test_end_req(te4),
        .dct_buffer(buf4), .dct_count(cnt4),
        .pkt_valid(pv4), .pkt_ready(pr4),
        .test_ending(ending4), .test_has_ended(ended4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Consume a packet from the CNT_MAX=4 instance if it is handed off at the next edge.
    task automatic sb_take(input logic last_phase);
        logic [1:0] e;
        if (pv4 && pr4) begin
            n_pkt4++;
            if (last_phase)
                chk("t6_last_cnt_range", 32'((cnt4 >= 4'd1) && (cnt4 <= 4'd4)), 1);
            else
                chk("t6_pkt_cnt", cnt4, 4);
            for (int j = int'(cnt4) - 1; j >= 0; j--) begin
                chk("t6_atom_avail", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("t6_atom", buf4[2*j +: 2], e);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int cyc;
        int seen;
        int stalls;

        reset_n = 1'b0;
        {v15, f15, te15, d15} = '0;
        {v4, f4, te4, d4} = '0;
        pr15 = 1'b1;
        pr4  = 1'b0;
        pushed = 0;
        n_pkt4 = 0;

        // reset values
        #3;
        chk("rst_buf", buf15, 0);
        chk("rst_cnt", cnt15, 0);
        chk("rst_pv", pv15, 0);
        chk("rst_ending", ending15, 0);
        chk("rst_ended", ended15, 0);
        #9 reset_n = 1'b1;
        #1;
        chk("rdy_after_rst", rdy15, 1);

        // full packet of 15 atoms 3,2,1,0,...
        for (int i = 0; i < 15; i++) begin
            v15 = 1'b1;
            d15 = 2'(3 - (i % 4));
            tick();
        end
        chk("t1_pv_not_yet", pv15, 0);
        chk("t1_rdy_full", rdy15, 1);
        v15 = 1'b0;
        tick();
        chk("t1_pv", pv15, 1);
        chk("t1_cnt", cnt15, 15);
        chk("t1_buf", buf15, 30'h39393939);
        chk("t1_rdy", rdy15, 1);
        tick();
        chk("t1_pv_clear", pv15, 0);

        // back-pressure: 30 atoms with pkt_ready low
        pr15 = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 30 && cyc < 60) begin
            v15 = 1'b1;
            d15 = 2'(acc % 4);
            #1;
            if (rdy15) acc++;
            tick();
            cyc++;
        end
        v15 = 1'b0;
        chk("t2_accepted", acc, 30);
        chk("t2_no_stall", cyc, 30);
        chk("t2_rdy_drop", rdy15, 0);
        chk("t2_pv", pv15, 1);
        chk("t2_cnt1", cnt15, 15);
        chk("t2_buf1", buf15, 30'h06C6C6C6);
        tick();
        tick();
        chk("t2_buf1_hold", buf15, 30'h06C6C6C6);
        pr15 = 1'b1;
        #1;
        chk("t2_rdy_slot_free", rdy15, 1);
        tick();
        chk("t2_pv2", pv15, 1);
        chk("t2_cnt2", cnt15, 15);
        chk("t2_buf2", buf15, 30'h31B1B1B1);
        tick();
        chk("t2_pv2_clear", pv15, 0);

        // flush of a 3-atom partial, then flush of an empty register
        for (int i = 0; i < 3; i++) begin
            v15 = 1'b1;
            d15 = 2'(i + 1);
            tick();
        end
        v15 = 1'b0;
        f15 = 1'b1;
        tick();
        f15 = 1'b0;
        chk("t3_pv_pending", pv15, 0);
        tick();
        chk("t3_pv", pv15, 1);
        chk("t3_cnt", cnt15, 3);
        chk("t3_buf", buf15, 30'h1B);
        tick();
        chk("t3_pv_clear", pv15, 0);
        f15 = 1'b1;
        tick();
        f15 = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (pv15) seen = 1;
            tick();
        end
        chk("t3_empty_flush", seen, 0);

        // asynchronous reset pulse with a held packet and a partial fill
        pr15 = 1'b0;
        for (int i = 0; i < 23; i++) begin
            v15 = 1'b1;
            d15 = 2'd3;
            tick();
        end
        v15 = 1'b0;
        chk("t5_pv_before", pv15, 1);
        chk("t5_cnt_before", cnt15, 15);
        chk("t5_buf_before", buf15, 30'h3FFFFFFF);
        #3;
        reset_n = 1'b0;
        #0.5;
        chk("t5_rst_pv", pv15, 0);
        chk("t5_rst_cnt", cnt15, 0);
        chk("t5_rst_buf", buf15, 0);
        #0.5;
        reset_n = 1'b1;
        pr15 = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pv15) seen = 1;
        end
        chk("t5_no_stale_pkt", seen, 0);
        v15 = 1'b1;
        d15 = 2'd1;
        tick();
        d15 = 2'd2;
        tick();
        v15 = 1'b0;
        f15 = 1'b1;
        tick();
        f15 = 1'b0;
        tick();
        chk("t5_pv", pv15, 1);
        chk("t5_cnt", cnt15, 2);
        chk("t5_buf", buf15, 30'h6);
        tick();

        // drain: 5th atom arrives with test_end_req
        for (int i = 0; i < 4; i++) begin
            v15 = 1'b1;
            d15 = 2'(i);
            tick();
        end
        d15 = 2'd0;
        te15 = 1'b1;
        tick();
        v15 = 1'b0;
        te15 = 1'b0;
        chk("t4_ending", ending15, 1);
        chk("t4_rdy", rdy15, 0);
        chk("t4_ended_not_yet", ended15, 0);
        chk("t4_pv_not_yet", pv15, 0);
        tick();
        chk("t4_pv", pv15, 1);
        chk("t4_cnt", cnt15, 5);
        chk("t4_buf", buf15, 30'h06C);
        chk("t4_ending_hold", ending15, 1);
        tick();
        chk("t4_ended", ended15, 1);
        chk("t4_ending_off", ending15, 0);
        chk("t4_pv_clear", pv15, 0);
        v15 = 1'b1;
        f15 = 1'b1;
        te15 = 1'b1;
        #1;
        chk("t4_rdy_ended", rdy15, 0);
        tick();
        f15 = 1'b0;
        te15 = 1'b0;
        tick();
        tick();
        v15 = 1'b0;
        chk("t4_flush_ignored", pv15, 0);
        chk("t4_ended_sticky", ended15, 1);
        chk("t4_ending_stays_off", ending15, 0);

        // CNT_MAX=4 stream: sustained phase, random back-pressure, final flush
        stalls = 0;
        cyc = 0;
        while (pushed < 100 && cyc < 2000) begin
            if (cyc < 20) begin
                pr4 = 1'b1;
                v4  = 1'b1;
            end else begin
                pr4 = 1'($urandom_range(0, 1));
                v4  = 1'($urandom_range(0, 1));
            end
            d4 = 2'($urandom_range(0, 3));
            #1;
            if (cyc < 20 && !rdy4) stalls++;
            if (v4 && rdy4) begin
                sb_q.push_back(d4);
                pushed++;
            end
            sb_take(1'b0);
            tick();
            cyc++;
        end
        chk("t6_no_stall_sustained", stalls, 0);
        chk("t6_pushed", pushed, 100);
        v4 = 1'b0;
        f4 = 1'b1;
        pr4 = 1'b1;
        #1;
        sb_take(1'b1);
        tick();
        f4 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            sb_take(1'b1);
            tick();
        end
        chk("t6_all_consumed", sb_q.size(), 0);
        chk("t6_pkt_total", 32'(n_pkt4 >= 25), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lab7_sos_nios2_qsys_0_oci_dct_packer.md
LAB7_SOS_NIOS2_QSYS_0_OCI_DCT_PACKER -- requirements
Module: lab7_sos_nios2_qsys_0_oci_dct_packer

Interface
REQ-001 Parameter: CNT_MAX, default 15, atoms per full packet, legal range 1..15.
REQ-002 clk  input  1  single clock; all state is updated on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 atom_valid  input  1  trace atom offered this cycle.
REQ-005 atom_data  input  2  2-bit trace atom.
REQ-006 atom_ready  output  1  packer accepts the atom this cycle.
REQ-007 flush  input  1  single-cycle request to emit the partial packet.
REQ-008 test_end_req  input  1  single-cycle request to drain and end the trace.
REQ-009 dct_buffer  output  30  packed atoms; newest atom in bits [1:0].
REQ-010 dct_count  output  4  number of valid atoms in dct_buffer.
REQ-011 pkt_valid  output  1  dct_buffer and dct_count hold a packet.
REQ-012 pkt_ready  input  1  consumer takes the packet this cycle.
REQ-013 test_ending  output  1  drain in progress.
REQ-014 test_has_ended  output  1  drain complete; sticky.

Function
REQ-015 The internal fill register fill_buf[29:0] and fill_cnt[3:0] SHALL accept an atom when atom_valid&&atom_ready: fill_buf <= {fill_buf[27:0],atom_data} and fill_cnt +1.
REQ-016 The output slot SHALL be free when !pkt_valid || pkt_ready.
REQ-017 A transfer SHALL occur when the slot is free and fill_cnt>0 and any of the following holds: fill_cnt==CNT_MAX, flush_pend, or state==DRAIN.
REQ-018 On a transfer: dct_buffer<=fill_buf, dct_count<=fill_cnt, pkt_valid<=1, and the fill register clears.
REQ-019 An atom accepted in the same cycle as a transfer SHALL yield fill_buf={28'b0,atom_data}, fill_cnt=1, with no atom lost or duplicated.
REQ-020 pkt_ready with no transfer SHALL clear pkt_valid next cycle.
REQ-021 dct_buffer and dct_count SHALL hold stable while pkt_valid && !pkt_ready.
REQ-022 atom_ready = (state==RUN) && (fill_cnt<CNT_MAX || slot free); it is combinational and does not depend on atom_valid.
REQ-023 flush SHALL set flush_pend.
REQ-024 flush_pend SHALL clear on the next transfer, or immediately if fill_cnt==0 and no atom is accepted that cycle.
REQ-025 A flush with an empty fill register SHALL emit no packet.
REQ-026 States SHALL be RUN, DRAIN and ENDED.
REQ-027 RUN->DRAIN on test_end_req; an atom accepted in that same cycle is kept.
REQ-028 In DRAIN: atom_ready=0 and test_ending=1.
REQ-029 DRAIN->ENDED when fill_cnt==0 && (!pkt_valid || pkt_ready).
REQ-030 In ENDED: test_has_ended=1, test_ending=0, atom_ready=0, and flush and test_end_req are ignored; ENDED is left only by reset.
REQ-031 test_end_req in DRAIN or ENDED SHALL have no effect.
REQ-032 flush and test_end_req in the same cycle SHALL behave as test_end_req.
REQ-033 fill_cnt SHALL never exceed CNT_MAX; dct_count of every emitted packet is in the range 1..CNT_MAX.
REQ-034 Throughput: one atom per cycle sustained while pkt_ready=1; minimum latency from the CNT_MAX-th atom to pkt_valid is 1 cycle.

Reset
REQ-035 While reset_n=0, outputs SHALL take these values: dct_buffer=0, dct_count=0, pkt_valid=0, test_ending=0, test_has_ended=0.
REQ-036 While reset_n=0, internal state SHALL take these values: fill_buf=0, fill_cnt=0, flush_pend=0, state=RUN.
REQ-037 Reset asserted mid-packet or mid-drain SHALL discard all content; no packet is emitted after release until new atoms arrive.
REQ-038 After reset release, atom_ready=1 on the first clk edge.

Verification
REQ-039 15 atoms 3,2,1,0,3,... with pkt_ready=1 -> pkt_valid one cycle after the 15th atom; dct_count=15; dct_buffer bits [29:28]=3 and bits [1:0]=the 15th atom; atom_ready stays 1.
REQ-040 pkt_ready=0, 30 atoms -> first packet held stable; atom_ready drops after the 30th atom; raising pkt_ready gives a second packet of count 15 with no loss.
REQ-041 3 atoms (1,2,3), then flush -> packet dct_count=3, dct_buffer=30'h1B; flush with an empty fill register -> no pkt_valid.
REQ-042 5 atoms, then test_end_req with pkt_ready=1 -> test_ending=1, atom_ready=0, a count-5 packet is emitted, then test_has_ended=1 and stays 1; a later flush has no effect.
REQ-043 reset_n pulsed low for 1 ns mid-fill (8 atoms) asynchronously to clk -> outputs go to 0 immediately; the next packet contains only post-reset atoms.
REQ-044 Atom accepted in the transfer cycle at CNT_MAX=4 -> packets of count 4 back-to-back, with no atom dropped over 100 random atoms under random pkt_ready.
